// File: rtl/ets_sweep_ctrl.sv
// ETS phase-sweep controller: steps the phase shifter through N positions,
// waits a settle time after each change, runs the ETS accumulator once per
// step and streams one (count, step) beat per step.
module ets_sweep_ctrl #(
  parameter int unsigned STEP_W   = 8,
  parameter int unsigned SETTLE_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_start,
  input  logic [STEP_W-1:0]   cfg_num_steps,
  input  logic [SETTLE_W-1:0] cfg_settle,
  input  logic                abort,
  output logic [STEP_W-1:0]   step_idx,
  output logic                acc_start,
  input  logic                acc_done,
  input  logic [31:0]         acc_data,
  output logic [31:0]         m_tdata,
  output logic [STEP_W-1:0]   m_tuser,
  output logic                m_tvalid,
  output logic                m_tlast,
  input  logic                m_tready,
  output logic                busy,
  output logic                sweep_done
);

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StAcq,
    StRel,
    StOut,
    StAbort
  } state_e;

  state_e              state_q;
  logic [STEP_W-1:0]   num_q;
  logic [SETTLE_W-1:0] settle_q;
  logic [SETTLE_W-1:0] cnt_q;
  logic                abort_pend_q;

  logic [SETTLE_W-1:0] cfg_load;
  logic [SETTLE_W-1:0] lat_load;
  logic                last_step;

  // Settle counter preload: a zero settle time still costs one cycle.
  always_comb begin
    cfg_load  = (cfg_settle == '0) ? '0 : cfg_settle - SETTLE_W'(1);
    lat_load  = (settle_q == '0) ? '0 : settle_q - SETTLE_W'(1);
    last_step = (step_idx == num_q - STEP_W'(1));
  end

  // Sweep FSM with all outputs registered; async reset drops acc_start at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      num_q        <= '0;
      settle_q     <= '0;
      cnt_q        <= '0;
      abort_pend_q <= 1'b0;
      step_idx     <= '0;
      acc_start    <= 1'b0;
      m_tdata      <= '0;
      m_tuser      <= '0;
      m_tvalid     <= 1'b0;
      m_tlast      <= 1'b0;
      busy         <= 1'b0;
      sweep_done   <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cfg_start) begin
            if (cfg_num_steps == '0) begin
              sweep_done <= 1'b1;
            end else begin
              num_q    <= cfg_num_steps;
              settle_q <= cfg_settle;
              cnt_q    <= cfg_load;
              step_idx <= '0;
              busy     <= 1'b1;
              state_q  <= StSettle;
            end
          end
        end
        StSettle: begin
          if (abort) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end else if (cnt_q == '0) begin
            acc_start <= 1'b1;
            state_q   <= StAcq;
          end else begin
            cnt_q <= cnt_q - SETTLE_W'(1);
          end
        end
        StAcq: begin
          // Abort beats a simultaneous done: nothing is captured.
          if (abort) begin
            acc_start <= 1'b0;
            state_q   <= StAbort;
          end else if (acc_done) begin
            m_tdata   <= acc_data;
            m_tuser   <= step_idx;
            acc_start <= 1'b0;
            state_q   <= StRel;
          end
        end
        StRel: begin
          if (abort) begin
            state_q <= StAbort;
          end else if (!acc_done) begin
            m_tvalid <= 1'b1;
            m_tlast  <= last_step;
            state_q  <= StOut;
          end
        end
        StOut: begin
          if (m_tready) begin
            m_tvalid     <= 1'b0;
            abort_pend_q <= 1'b0;
            if (abort_pend_q || abort) begin
              busy    <= 1'b0;
              state_q <= StIdle;
            end else if (m_tlast) begin
              busy       <= 1'b0;
              sweep_done <= 1'b1;
              state_q    <= StIdle;
            end else begin
              step_idx <= step_idx + STEP_W'(1);
              cnt_q    <= lat_load;
              state_q  <= StSettle;
            end
          end else if (abort) begin
            abort_pend_q <= 1'b1;
          end
        end
        StAbort: begin
          if (!acc_done) begin
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ets_sweep_ctrl.sv
// Self-checking bench for ets_sweep_ctrl: directed scenarios plus randomized
// sweeps, checked every cycle against a step-lifecycle reference model.
module tb_ets_sweep_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_start = 1'b0;
  logic [7:0]  cfg_num_steps = '0;
  logic [15:0] cfg_settle = '0;
  logic        abort = 1'b0;
  logic [7:0]  step_idx;
  logic        acc_start;
  logic        acc_done = 1'b0;
  logic [31:0] acc_data = '0;
  logic [31:0] m_tdata;
  logic [7:0]  m_tuser;
  logic        m_tvalid;
  logic        m_tlast;
  logic        m_tready = 1'b0;
  logic        busy;
  logic        sweep_done;

  ets_sweep_ctrl #(.STEP_W(8), .SETTLE_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_num_steps(cfg_num_steps),
    .cfg_settle(cfg_settle), .abort(abort), .step_idx(step_idx), .acc_start(acc_start),
    .acc_done(acc_done), .acc_data(acc_data), .m_tdata(m_tdata), .m_tuser(m_tuser),
    .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tready(m_tready), .busy(busy),
    .sweep_done(sweep_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: each step is wait-settle -> acquire -> release -> deliver.
  localparam int PIdle = 0, PSettle = 1, PAcq = 2, PRel = 3, POut = 4, PAbort = 5;
  int          ph;
  int          m_n, m_s, m_left, m_step;
  bit          m_pend;
  bit          e_busy, e_acc, e_valid, e_last, e_done;
  logic [31:0] e_data;
  int          e_user;

  task automatic model_reset();
    ph = PIdle; m_n = 0; m_s = 0; m_left = 0; m_step = 0; m_pend = 0;
    e_busy = 0; e_acc = 0; e_valid = 0; e_last = 0; e_done = 0; e_data = '0; e_user = 0;
  endtask

  // Advance the model across one rising edge using the inputs presented now.
  task automatic model_step();
    e_done = 0;
    case (ph)
      PIdle: if (cfg_start) begin
        if (cfg_num_steps == 0) e_done = 1;
        else begin
          m_n = int'(cfg_num_steps); m_s = int'(cfg_settle); m_step = 0;
          m_left = (m_s == 0) ? 1 : m_s; e_busy = 1; ph = PSettle;
        end
      end
      PSettle: if (abort) begin ph = PIdle; e_busy = 0; end
      else begin
        m_left--;
        if (m_left == 0) begin e_acc = 1; ph = PAcq; end
      end
      PAcq: if (abort) begin e_acc = 0; ph = PAbort; end
      else if (acc_done) begin e_data = acc_data; e_user = m_step; e_acc = 0; ph = PRel; end
      PRel: if (abort) ph = PAbort;
      else if (!acc_done) begin e_valid = 1; e_last = (m_step == m_n - 1); ph = POut; end
      POut: begin
        if (m_tready) begin
          e_valid = 0;
          if (m_pend || abort) begin ph = PIdle; e_busy = 0; end
          else if (e_last) begin ph = PIdle; e_busy = 0; e_done = 1; end
          else begin m_step++; m_left = (m_s == 0) ? 1 : m_s; ph = PSettle; end
          m_pend = 0;
        end else if (abort) m_pend = 1;
      end
      PAbort: if (!acc_done) begin ph = PIdle; e_busy = 0; end
      default: ph = PIdle;
    endcase
  endtask

  // Accumulator stand-in and event logs.
  int acq_min = 1, acq_max = 1, rel_min = 0, rel_max = 0;
  int acq_cnt = 0, rel_cnt = 0;
  bit dir_data = 0, abort_with_done = 0;
  logic [31:0] bt_data[$];
  int          bt_user[$];
  int          bt_last[$];
  int          settle_q[$];
  int rises = 0, dones = 0, ev_cyc = 0, hs_cyc = 0, done_cyc = 0;
  bit prev_acc = 0, busy_seen = 0;

  task automatic respond();
    if (acc_start && !acc_done) begin
      if (acq_cnt == 0) begin
        acc_done = 1;
        acc_data = dir_data ? 32'(10 * (int'(step_idx) + 1)) : $urandom;
        if (abort_with_done) abort = 1;
        rel_cnt = $urandom_range(rel_max, rel_min);
      end else acq_cnt--;
    end else if (!acc_start && acc_done) begin
      if (rel_cnt == 0) acc_done = 0;
      else rel_cnt--;
    end else if (!acc_start && !acc_done) begin
      acq_cnt = $urandom_range(acq_max, acq_min);
      acc_data = $urandom;
    end
  endtask

  task automatic compare();
    check("busy", 32'(busy), 32'(e_busy));
    check("acc_start", 32'(acc_start), 32'(e_acc));
    check("m_tvalid", 32'(m_tvalid), 32'(e_valid));
    check("sweep_done", 32'(sweep_done), 32'(e_done));
    if (e_busy) check("step_idx", 32'(step_idx), m_step);
    if (e_valid) begin
      check("m_tdata", m_tdata, e_data);
      check("m_tuser", 32'(m_tuser), e_user);
      check("m_tlast", 32'(m_tlast), 32'(e_last));
    end
  endtask

  task automatic tick();
    if (m_tvalid && m_tready) begin
      bt_data.push_back(m_tdata); bt_user.push_back(int'(m_tuser));
      bt_last.push_back(int'(m_tlast)); hs_cyc = cyc;
      if (!m_tlast) ev_cyc = cyc + 1;
    end
    if (ph == PIdle && cfg_start && cfg_num_steps != 0) ev_cyc = cyc + 1;
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    compare();
    if (acc_start && !prev_acc) begin rises++; settle_q.push_back(cyc - ev_cyc); end
    prev_acc = acc_start;
    if (sweep_done) begin dones++; done_cyc = cyc; end
    if (busy) busy_seen = 1;
    abort = 0;
    respond();
  endtask

  task automatic do_reset();
    rst_n = 0;
    #1;
    check("rst_step_idx", 32'(step_idx), 0);
    check("rst_acc_start", 32'(acc_start), 0);
    check("rst_m_tdata", m_tdata, 0);
    check("rst_m_tuser", 32'(m_tuser), 0);
    check("rst_m_tvalid", 32'(m_tvalid), 0);
    check("rst_m_tlast", 32'(m_tlast), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_sweep_done", 32'(sweep_done), 0);
    model_reset();
    acc_done = 0; abort = 0; cfg_start = 0; prev_acc = 0; acq_cnt = acq_min;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic start_sweep(int n, int s);
    cfg_num_steps = 8'(n); cfg_settle = 16'(s); cfg_start = 1;
    tick();
    cfg_start = 0;
  endtask

  task automatic wait_idle(int budget, string name);
    for (int i = 0; i < budget && busy; i++) tick();
    check(name, 32'(busy), 0);
  endtask

  task automatic clear_logs();
    bt_data.delete(); bt_user.delete(); bt_last.delete(); settle_q.delete();
  endtask

  int d0, r0;
  logic [31:0] td0;
  int tu0;

  initial begin
    model_reset();
    #2;
    do_reset();

    // Three-step sweep with known counts and 4-cycle settle.
    dir_data = 1; acq_min = 2; acq_max = 2; rel_min = 1; rel_max = 1; m_tready = 1;
    clear_logs(); d0 = dones;
    start_sweep(3, 4);
    wait_idle(200, "s1_idle");
    check("s1_beats", bt_data.size(), 3);
    for (int i = 0; i < 3 && i < bt_data.size(); i++) begin
      check("s1_data", bt_data[i], 32'(10 * (i + 1)));
      check("s1_user", bt_user[i], i);
      check("s1_last", bt_last[i], (i == 2) ? 1 : 0);
    end
    check("s1_settles", settle_q.size(), 3);
    foreach (settle_q[i]) check("s1_settle_len", settle_q[i], 4);
    check("s1_done_count", dones - d0, 1);
    check("s1_done_delay", done_cyc - hs_cyc, 1);

    // Back-pressure on beat 0 for 20 cycles.
    tick();
    m_tready = 0; clear_logs();
    start_sweep(2, 1);
    for (int i = 0; i < 100 && !m_tvalid; i++) tick();
    check("s2_valid", 32'(m_tvalid), 1);
    td0 = m_tdata; tu0 = int'(m_tuser); r0 = rises;
    repeat (20) tick();
    check("s2_data_stable", m_tdata, td0);
    check("s2_user_stable", 32'(m_tuser), tu0);
    check("s2_user0", tu0, 0);
    check("s2_no_restart", rises - r0, 0);
    m_tready = 1;
    wait_idle(200, "s2_idle");
    check("s2_beats", bt_data.size(), 2);

    // Zero-length sweep.
    tick();
    d0 = dones; r0 = rises; busy_seen = 0;
    start_sweep(0, 3);
    repeat (3) tick();
    check("s3_done", dones - d0, 1);
    check("s3_busy", 32'(busy_seen), 0);
    check("s3_acc", rises - r0, 0);

    // Zero settle time means one settle cycle.
    clear_logs();
    start_sweep(2, 0);
    wait_idle(200, "s4_idle");
    check("s4_settles", settle_q.size(), 2);
    foreach (settle_q[i]) check("s4_settle_len", settle_q[i], 1);

    // Abort during the acquisition of step 2.
    acq_min = 3; acq_max = 3; clear_logs(); d0 = dones;
    start_sweep(5, 2);
    for (int i = 0; i < 300 && !(acc_start && step_idx == 2); i++) tick();
    check("s5_reach_acq2", 32'(acc_start && step_idx == 2), 1);
    abort = 1;
    tick();
    check("s5_acc_drop", 32'(acc_start), 0);
    wait_idle(50, "s5_idle");
    check("s5_beats", bt_data.size(), 2);
    check("s5_no_done", dones - d0, 0);

    // Abort coinciding with acc_done.
    abort_with_done = 1; rel_min = 2; rel_max = 2; clear_logs(); d0 = dones;
    start_sweep(3, 1);
    wait_idle(100, "s6_idle");
    abort_with_done = 0;
    check("s6_beats", bt_data.size(), 0);
    check("s6_no_done", dones - d0, 0);

    // Reset while releasing, then a fresh sweep from step 0.
    rel_min = 4; rel_max = 4; acq_min = 1; acq_max = 1;
    start_sweep(3, 1);
    for (int i = 0; i < 100 && ph != PRel; i++) tick();
    check("s7_reach_rel", 32'(busy && !acc_start && acc_done), 1);
    do_reset();
    rel_min = 0; rel_max = 1; clear_logs(); d0 = dones;
    start_sweep(2, 2);
    wait_idle(200, "s7_idle");
    check("s7_beats", bt_data.size(), 2);
    if (bt_data.size() > 0) begin
      check("s7_user0", bt_user[0], 0);
      check("s7_data0", bt_data[0], 10);
    end
    check("s7_done", dones - d0, 1);

    // Reset while acquiring drops acc_start asynchronously.
    acq_min = 6; acq_max = 6;
    start_sweep(2, 1);
    for (int i = 0; i < 50 && !acc_start; i++) tick();
    check("s8_acq", 32'(acc_start), 1);
    do_reset();

    // Randomized sweeps with mid-sweep cfg changes, stray starts and aborts.
    dir_data = 0; acq_min = 0; acq_max = 4; rel_min = 0; rel_max = 3;
    for (int i = 0; i < 3000; i++) begin
      cfg_start = ($urandom_range(15, 0) == 0);
      cfg_num_steps = 8'($urandom_range(6, 0));
      cfg_settle = 16'($urandom_range(5, 0));
      m_tready = ($urandom_range(9, 0) < 7);
      abort = ($urandom_range(79, 0) == 0);
      tick();
    end
    cfg_start = 0; abort = 0; m_tready = 1;
    wait_idle(500, "rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ets_sweep_ctrl.md
ETS_SWEEP_CTRL -- requirements
Module: ets_sweep_ctrl

Interface
REQ-001 Parameter STEP_W, default 8, SHALL set the width of the step index and step count.
REQ-002 Parameter SETTLE_W, default 16, SHALL set the width of the settle-time count.
REQ-003 clk  input  1  SHALL be the clock; all logic is rising-edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 cfg_start  input  1  SHALL request a sweep; sampled only in IDLE.
REQ-006 cfg_num_steps  input  STEP_W  SHALL give the number of phase steps N.
REQ-007 cfg_settle  input  SETTLE_W  SHALL give the settle cycles S after each step change.
REQ-008 abort  input  1  SHALL request early termination of the sweep.
REQ-009 step_idx  output  STEP_W  SHALL be the current phase-step index, driven to the phase shifter.
REQ-010 acc_start  output  1  SHALL be the level start to the ETS accumulator.
REQ-011 acc_done  input  1  SHALL be the level done from the accumulator.
REQ-012 acc_data  input  32  SHALL be the accumulator hit count, valid while acc_done=1.
REQ-013 m_tdata  output  32  SHALL carry the captured count; m_tuser (STEP_W) SHALL carry its step index.
REQ-014 m_tvalid, m_tlast  output  1 each; m_tready  input  1  SHALL form the result stream handshake.
REQ-015 busy  output  1; sweep_done  output  1  SHALL indicate an active sweep and a one-cycle completion pulse, respectively.

Function
REQ-016 FSM states SHALL be IDLE, SETTLE, ACQ, REL, OUT, ABORT; all outputs registered.
REQ-017 IDLE: when cfg_start=1, the block SHALL latch N and S, clear step_idx to 0, and go to SETTLE; if N=0, it SHALL instead stay in IDLE and pulse sweep_done the next cycle.
REQ-018 SETTLE SHALL last max(S,1) cycles, then go to ACQ; acc_done SHALL be ignored in SETTLE.
REQ-019 ACQ SHALL hold acc_start=1; on acc_done=1 the block SHALL capture acc_data into m_tdata and step_idx into m_tuser, then go to REL.
REQ-020 REL SHALL hold acc_start=0 until acc_done=0, then go to OUT; this guarantees the accumulator is cleared.
REQ-021 OUT SHALL assert m_tvalid with m_tlast=(step_idx==N-1); m_tdata, m_tuser and m_tlast SHALL stay stable until m_tvalid and m_tready are both 1.
REQ-022 On an OUT handshake: if m_tlast=1, the block SHALL go to IDLE and pulse sweep_done; otherwise it SHALL increment step_idx and go to SETTLE.
REQ-023 step_idx SHALL change only on an OUT handshake or on IDLE start; it SHALL never wrap within a sweep.
REQ-024 busy SHALL be 1 in every state except IDLE.
REQ-025 cfg_start outside IDLE SHALL be ignored; cfg_* changes mid-sweep SHALL have no effect.
REQ-026 abort in SETTLE SHALL go directly to IDLE.
REQ-027 abort in ACQ or REL SHALL go to ABORT: acc_start=0, wait for acc_done=0, then go to IDLE.
REQ-028 abort in OUT SHALL be remembered and take effect after the handshake, going to IDLE.
REQ-029 An aborted sweep SHALL NOT pulse sweep_done.
REQ-030 If abort and acc_done rise in the same ACQ cycle, abort SHALL win: no capture, go to ABORT.

Reset
REQ-031 With rst_n=0: state=IDLE; step_idx, acc_start, m_tdata, m_tuser, m_tvalid, m_tlast, busy and sweep_done SHALL all be 0; pending abort SHALL be cleared.
REQ-032 A reset asserted mid-sweep SHALL drop acc_start immediately (asynchronously); no partial stream beat SHALL remain after release.

Verification
REQ-033 N=3, S=4, accumulator model returns 10,20,30, m_tready=1 -> three beats (10,0),(20,1),(30,2) with tlast on the third; sweep_done 1 cycle after; 4 settle cycles before each acc_start rise.
REQ-034 N=2, m_tready held 0 for 20 cycles on beat 0 -> m_tdata and m_tuser stable, no second acc_start until the handshake.
REQ-035 N=0, cfg_start pulse -> sweep_done pulse, busy stays 0, no acc_start.
REQ-036 N=5, abort in ACQ of step 2 -> acc_start falls next cycle, IDLE after acc_done=0, 2 beats total, no sweep_done.
REQ-037 S=0 -> SETTLE lasts exactly 1 cycle.
REQ-038 abort and acc_done rise in the same ACQ cycle -> no beat emitted, ABORT path taken.
REQ-039 rst_n low during REL -> all outputs 0; a fresh sweep after release runs correctly from step 0.
